aes_192_decrypt_iter: RTL and testbench

AES_192_DECRYPT_ITER -- requirements
Module: aes_192_decrypt_iter

---
 rtl/aes_192_decrypt_iter.sv | 243 ++++++++++++++++++++++++
 tb/tb_aes_192_decrypt_iter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_192_decrypt_iter.sv
// Iterative AES-192 inverse cipher: 8-cycle key expansion, then 13 round cycles.
// Optional AES_DEC_KEY_CACHE_EN skips key expansion when the key repeats.
module aes_192_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state,
  input  logic [191:0] key,
  output logic [127:0] out,
  output logic         out_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;

  fsm_t         fsm_q;
  logic         start_r_q;
  logic         start_posedge;
  logic [3:0]   kcnt_q;
  logic [3:0]   rcnt_q;
  logic [127:0] st_q;
  logic [127:0] out_q;
  logic [191:0] key_q;
  logic         valid_q;
  logic         busy_q;
  logic [31:0]  wk_q [52];

  logic [5:0]   kbase;
  logic [31:0]  win [6];
  logic [31:0]  nw [6];
  logic [5:0]   widx [6];
  logic [7:0]   rcon;
  logic [5:0]   ridx;
  logic [127:0] rk;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;

`ifdef AES_DEC_KEY_CACHE_EN
  logic cv_q;
  logic hit;
  assign hit = cv_q & (key == key_q);
`endif

  assign start_posedge = start & ~start_r_q;
  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] p;
    s = gmul(x, x);
    p = s;
    for (int i = 0; i < 6; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = isbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Next six schedule words from the previous six, plus the round datapath
  always_comb begin
    kbase = {2'b00, kcnt_q - 4'd1} * 6'd6;
    for (int j = 0; j < 6; j++) begin
      win[j] = (kcnt_q == 4'd1) ? key_q[191-32*j -: 32]
                                : wk_q[kbase + 6'(j)];
    end
    rcon  = 8'h01 << (kcnt_q - 4'd1);
    nw[0] = win[0] ^ subword({win[5][23:0], win[5][31:24]})
          ^ {rcon, 24'h000000};
    for (int j = 1; j < 6; j++) begin
      nw[j] = win[j] ^ nw[j-1];
    end
    for (int j = 0; j < 6; j++) begin
      widx[j] = kbase + 6'd6 + 6'(j);
    end
    ridx = {rcnt_q, 2'b00};
    rk   = {wk_q[ridx], wk_q[ridx + 6'd1],
            wk_q[ridx + 6'd2], wk_q[ridx + 6'd3]};
    isb  = inv_sub_bytes(inv_shift_rows(st_q));
    ark  = isb ^ rk;
    imc  = inv_mix(ark);
  end

  // Control FSM, key schedule storage and round state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      start_r_q <= 1'b0;
      kcnt_q    <= '0;
      rcnt_q    <= '0;
      st_q      <= '0;
      out_q     <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < 52; i++) wk_q[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cv_q      <= 1'b0;
`endif
    end else begin
      start_r_q <= start;
      unique case (fsm_q)
        IDLE, DONE: begin
          if (start_posedge) begin
            st_q    <= state;
            key_q   <= key;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            for (int j = 0; j < 6; j++) begin
              wk_q[j] <= key[191-32*j -: 32];
            end
`ifdef AES_DEC_KEY_CACHE_EN
            if (hit) begin
              fsm_q  <= ROUND;
              rcnt_q <= 4'd12;
            end else begin
              fsm_q  <= KEXP;
              kcnt_q <= 4'd1;
              cv_q   <= 1'b0;
            end
`else
            fsm_q  <= KEXP;
            kcnt_q <= 4'd1;
`endif
          end
        end
        KEXP: begin
          for (int j = 0; j < 6; j++) begin
            if (widx[j] < 6'd52) wk_q[widx[j]] <= nw[j];
          end
          if (kcnt_q == 4'd8) begin
            fsm_q  <= ROUND;
            kcnt_q <= '0;
            rcnt_q <= 4'd12;
`ifdef AES_DEC_KEY_CACHE_EN
            cv_q   <= 1'b1;
`endif
          end else begin
            kcnt_q <= kcnt_q + 4'd1;
          end
        end
        ROUND: begin
          if (rcnt_q == 4'd12) begin
            st_q <= st_q ^ rk;
          end else if (rcnt_q != 4'd0) begin
            st_q <= imc;
          end
          if (rcnt_q == 4'd0) begin
            out_q   <= ark;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            fsm_q   <= DONE;
          end else begin
            rcnt_q <= rcnt_q - 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_192_decrypt_iter.sv
// Directed bench for aes_192_decrypt_iter using FIPS-197 and SP800-38A vectors.
// Latency of a repeated key depends on AES_DEC_KEY_CACHE_EN.
module tb_aes_192_decrypt_iter;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] state;
  logic [191:0] key;
  logic [127:0] out;
  logic         out_valid;
  logic         busy;

  int tests;
  int fails;

  localparam logic [191:0] K1 =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] K2 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] C2A = 128'hbd334f1d6e45f25ff712a214571fa5cc;
  localparam logic [127:0] P2A = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2B = 128'h974104846d0ad3ad7734ecb3ecee4eef;
  localparam logic [127:0] P2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int LAT_HIT = 13;
`else
  localparam int LAT_HIT = 21;
`endif

  aes_192_decrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state     (state),
    .key       (key),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the negedge after E0
  task automatic begin_req(input logic [191:0] k, input logic [127:0] s);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    key   = k;
    state = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Edges after E0 until out_valid, -1 if it never rises
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    state = '0;
    key   = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (out !== 128'h0) begin
      fails++;
      $display("FAIL reset_out: got %h want 0", out);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips_c2;
    int lat;
    begin_req(K1, C1);
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL c2_start: busy %b valid %b want 1 0", busy, out_valid);
    end
    wait_valid(lat);
    tests++;
    if (lat != 21) begin
      fails++;
      $display("FAIL c2_latency: got %0d want 21", lat);
    end
    tests++;
    if (out !== P1) begin
      fails++;
      $display("FAIL c2_out: got %h want %h", out, P1);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL c2_busy_done: got %b want 0", busy);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out !== P1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL c2_hold: valid %b busy %b out %h want 1 0 %h",
               out_valid, busy, out, P1);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    begin_req(K2, C2A);
    tests++;
    if (out_valid !== 1'b0 || out !== 128'h0) begin
      fails++;
      $display("FAIL b2b_drop: valid %b out %h want 0 0", out_valid, out);
    end
    wait_valid(lat);
    tests++;
    if (lat != 21 || out !== P2A) begin
      fails++;
      $display("FAIL b2b_result: lat %0d out %h want 21 %h", lat, out, P2A);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    lat = -1;
    begin_req(K1, C1);
    start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = e;
        break;
      end
      if (e == 4) begin
        key   = K2;
        state = C2A;
        start = 1'b1;
      end
      if (e == 5) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL ignore_busy: got %b want 1", busy);
        end
      end
    end
    tests++;
    if (lat != 21 || out !== P1) begin
      fails++;
      $display("FAIL ignore_result: lat %0d out %h want 21 %h", lat, out, P1);
    end
  endtask

  task automatic test_rst_abort;
    int lat;
    begin_req(K2, C2A);
    repeat (10) @(posedge clk);
    #2;
    rst   = 1'b1;
    start = 1'b0;
    #1;
    tests++;
    if (out !== 128'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_clear: out %h valid %b busy %b want 0 0 0",
               out, out_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: valid %b busy %b want 0 0", out_valid, busy);
    end
    begin_req(K1, C1);
    wait_valid(lat);
    tests++;
    if (lat != 21 || out !== P1) begin
      fails++;
      $display("FAIL abort_rerun: lat %0d out %h want 21 %h", lat, out, P1);
    end
  endtask

  task automatic test_key_cache;
    int lat;
    begin_req(K2, C2A);
    wait_valid(lat);
    tests++;
    if (lat != 21 || out !== P2A) begin
      fails++;
      $display("FAIL cache_first: lat %0d out %h want 21 %h", lat, out, P2A);
    end
    begin_req(K2, C2B);
    wait_valid(lat);
    tests++;
    if (lat != LAT_HIT || out !== P2B) begin
      fails++;
      $display("FAIL cache_repeat: lat %0d out %h want %0d %h",
               lat, out, LAT_HIT, P2B);
    end
    begin_req(K1, C1);
    wait_valid(lat);
    tests++;
    if (lat != 21 || out !== P1) begin
      fails++;
      $display("FAIL cache_newkey: lat %0d out %h want 21 %h", lat, out, P1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fips_c2();
    test_back_to_back();
    test_ignore_start();
    test_rst_abort();
    test_key_cache();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
